h264_transform_scheduler: RTL and testbench
===========================================

# h264_transform_scheduler

Shares one 4x4 core transform between a luma and a chroma residual requester. Arbitrates whole 4x4 blocks, feeds the granted block's four rows into the transform on consecutive cycles, and tracks block ownership in a tag FIFO. Each of the 16 zigzag coefficients coming back is labelled with source, tag and index. Sits between the residual generators and the quantiser.

## Interface
- TAGW, 6, width of per-block tag carried from requester to output
- TFIFO_DEPTH, 4, tag FIFO entries (power of two, ≥2)

- CLK  in  1  clock
- RESET  in  1  reset, synchronous, active-low
- REQ_VALID  in  2  per requester (0 = luma, 1 = chroma); block ready, held for all 4 rows
- REQ_ROW  in  2x36  current row per requester; 4 x 9-bit residuals, pixel 0 in lsbs
- REQ_TAG  in  2xTAGW  block tag, sampled at grant
- REQ_ACK  out  2  row consumed this cycle; requester advances to next row
- TR_READY  in  1  core transform can accept a block
- TR_ENABLE  out  1  row strobe to core transform
- TR_XXIN  out  36  row data to core transform
- TR_VALID  in  1  coefficient strobe from core transform
- TR_YNOUT  in  14  coefficient from core transform (zigzag order)
- OUT_VALID  out  1  labelled coefficient valid
- OUT_COEF  out  14  coefficient
- OUT_SRC  out  1  0 = luma, 1 = chroma
- OUT_TAG  out  TAGW  tag of owning block
- OUT_IDX  out  4  zigzag index 0..15
- OUT_LAST  out  1  high with OUT_IDX = 15
- ERR  out  2  sticky; [0] requester dropped REQ_VALID mid-block, [1] TR_VALID with tag FIFO empty

## Operation
- FSM states: IDLE, FEED, HOLD.
- IDLE -> FEED when TR_READY=1, any REQ_VALID=1, and tag FIFO not full. The grant and row counter (0) are registered, and {src, tag} is pushed to the FIFO in the same edge.
- FEED, rows 0..3, one per cycle:
  - REQ_ACK[g]=1 combinationally.
  - REQ_ROW[g] is registered to TR_XXIN with TR_ENABLE=1 on the next edge.
  - After row 3 -> HOLD.
- HOLD lasts 2 cycles with TR_ENABLE=0, letting the registered TR_READY deassert, then -> IDLE.
- Arbitration is round-robin. The pointer toggles to the other requester after each grant, and after reset it favours luma. With only one requester valid, that requester is granted regardless of the pointer.
- REQ_VALID[g]=0 during FEED:
  - set ERR[0];
  - still drive all 4 rows using REQ_ROW as presented, so the transform always gets whole blocks;
  - REQ_ACK[g] stays asserted.
- Output side:
  - Each TR_VALID beat is registered to OUT_* with the head-of-FIFO src/tag and a 4-bit beat counter as OUT_IDX.
  - At beat 15, OUT_LAST=1, the FIFO pops and the counter wraps to 0.
- TR_VALID with FIFO empty: set ERR[1], output src/tag = 0, counter still advances.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- FIFO full in IDLE: no grant, REQ_ACK=0.
- ERR bits clear only on reset.

## Timing
- Reset values:
  - REQ_ACK, TR_ENABLE, TR_XXIN, OUT_* and ERR all 0.
  - FSM in IDLE, FIFO empty, RR pointer = luma, beat counter 0.
- Grant edge to first TR_ENABLE: 2 cycles (first ACK cycle, then registered row).
- TR_ENABLE is high exactly 4 consecutive cycles per block.
- Minimum block-to-block spacing: 7 cycles (1 grant + 4 feed + 2 hold).
- TR_VALID to OUT_VALID: 1 cycle; no bubbles inserted on the output side.
- Reset mid-block aborts feed and output; the core transform shares RESET.

## Configuration
- H264_TS_LUMA_PRIO_EN defined: strict luma priority. Chroma is granted only when REQ_VALID[0]=0, and the RR pointer is unused.
- H264_TS_LUMA_PRIO_EN undefined: round-robin as above.

## Structure
- Package h264_ts_pkg:
  - state enum (IDLE, FEED, HOLD);
  - SRC_LUMA=1'b0 and SRC_CHROMA=1'b1;
  - packed struct tag_entry_t {src, tag};
  - HOLD_CYCLES=2 and ROWS_PER_BLK=4.
- Sub-module h264_ts_tagfifo:
  - synchronous FIFO of tag_entry_t, parameter TFIFO_DEPTH;
  - push, pop, head, full and empty ports;
  - occupancy counter with wrap-around pointers.

## Test plan
- Luma only, one block with rows 0x001..0x004 patterns, TR_READY=1 -> TR_ENABLE high 4 cycles starting 2 cycles after grant; TR_XXIN matches rows in order; REQ_ACK[0] pulses 4 times.
- Both requesters continuously valid -> grants alternate luma, chroma, luma; block starts 7 cycles apart; with H264_TS_LUMA_PRIO_EN, all grants go to luma.
- 16 TR_VALID beats for a chroma block with tag 0x2A -> OUT_SRC=1, OUT_TAG=0x2A, OUT_IDX 0..15, OUT_LAST only on index 15, FIFO empty afterwards.
- TR_READY held 0 with TFIFO_DEPTH blocks outstanding -> no grant and REQ_ACK=0 until a pop frees an entry, then grant on the next IDLE cycle.
- REQ_VALID[1] dropped at row 2 -> ERR[0]=1, 4 rows still issued; TR_VALID with empty FIFO -> ERR[1]=1.
- RESET=0 asserted mid-FEED -> next cycle all outputs 0, FSM IDLE; a fresh block afterwards is fed normally.

Source files
------------

// File: rtl/h264_ts_pkg.sv
// Shared types and constants for the h264 transform scheduler.
package h264_ts_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Requester identities, also the OUT_SRC encoding
    localparam logic SRC_LUMA   = 1'b0;
    localparam logic SRC_CHROMA = 1'b1;

    // Width of the tag stored per in-flight block; the top's TAGW should match
    localparam int TS_TAGW = 6;

    // Block timing
    localparam int HOLD_CYCLES  = 2;
    localparam int ROWS_PER_BLK = 4;

    // Ownership record for one block travelling through the core transform
    typedef struct packed {
        logic               src;
        logic [TS_TAGW-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/h264_ts_tagfifo.sv
// Tag FIFO: remembers which requester/tag owns each block in the transform.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module h264_ts_tagfifo
    import h264_ts_pkg::*;
#(
    parameter int TFIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       push_i,
    input  tag_entry_t push_data_i,
    input  logic       pop_i,
    output tag_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(TFIFO_DEPTH);
    localparam int CW = PW + 1;

    tag_entry_t      mem_q [TFIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(TFIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Occupancy next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array, written at the tail; contents need no reset
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally since depth is a power of two
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/h264_transform_scheduler.sv
// Shares one 4x4 core transform between luma (0) and chroma (1) requesters.
// Whole blocks are granted, rows are fed on consecutive cycles, and returning
// zigzag coefficients are labelled with owner src/tag and index.
// Build option: define H264_TS_LUMA_PRIO_EN for strict luma priority;
// otherwise arbitration is round-robin starting with luma.
module h264_transform_scheduler
    import h264_ts_pkg::*;
#(
    parameter int TAGW        = TS_TAGW,
    parameter int TFIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [1:0]           REQ_VALID,
    input  logic [1:0][35:0]     REQ_ROW,
    input  logic [1:0][TAGW-1:0] REQ_TAG,
    output logic [1:0]           REQ_ACK,
    input  logic                 TR_READY,
    output logic                 TR_ENABLE,
    output logic [35:0]          TR_XXIN,
    input  logic                 TR_VALID,
    input  logic [13:0]          TR_YNOUT,
    output logic                 OUT_VALID,
    output logic [13:0]          OUT_COEF,
    output logic                 OUT_SRC,
    output logic [TAGW-1:0]      OUT_TAG,
    output logic [3:0]           OUT_IDX,
    output logic                 OUT_LAST,
    output logic [1:0]           ERR
);

    // Handshake: a requester presents REQ_VALID plus its current row; in FEED
    // REQ_ACK[g] high means that row is captured at this edge and the
    // requester must present the next row in the following cycle.

    state_t          state_q;
    logic            gnt_q;
    logic [1:0]      row_q;
    logic [1:0]      hold_q;
    logic            tr_enable_q;
    logic [35:0]     tr_xxin_q;
    logic            err_feed_q;

    logic            out_valid_q;
    logic [13:0]     out_coef_q;
    logic            out_src_q;
    logic [TAGW-1:0] out_tag_q;
    logic [3:0]      out_idx_q;
    logic            out_last_q;
    logic [3:0]      beat_q;
    logic            err_empty_q;

    logic            gnt_sel_d;
    logic            grant_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    tag_entry_t      push_entry;
    tag_entry_t      head_entry;

`ifndef H264_TS_LUMA_PRIO_EN
    logic            rr_q;
`endif

    // Pick the requester that would win if a grant happens this cycle
    always_comb begin
        gnt_sel_d = SRC_LUMA;
`ifdef H264_TS_LUMA_PRIO_EN
        gnt_sel_d = REQ_VALID[0] ? SRC_LUMA : SRC_CHROMA;
`else
        if (&REQ_VALID) begin
            gnt_sel_d = rr_q;
        end else begin
            gnt_sel_d = REQ_VALID[0] ? SRC_LUMA : SRC_CHROMA;
        end
`endif
    end

    assign grant_d = (state_q == IDLE) && TR_READY && (|REQ_VALID) && !fifo_full;

    // Ownership record pushed at the grant edge
    always_comb begin
        push_entry     = '0;
        push_entry.src = gnt_sel_d;
        push_entry.tag = TS_TAGW'(REQ_TAG[gnt_sel_d]);
    end

    assign REQ_ACK = (state_q != FEED) ? 2'b00 : (gnt_q ? 2'b10 : 2'b01);

`ifndef H264_TS_LUMA_PRIO_EN
    // Round-robin pointer: after each grant, favour the other requester
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rr_q <= SRC_LUMA;
        end else if (grant_d) begin
            rr_q <= ~gnt_sel_d;
        end
    end
`endif

    // Block feed FSM: grant, four row strobes, then a hold for TR_READY to drop
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            gnt_q       <= SRC_LUMA;
            row_q       <= '0;
            hold_q      <= '0;
            tr_enable_q <= 1'b0;
            tr_xxin_q   <= '0;
            err_feed_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tr_enable_q <= 1'b0;
                    if (grant_d) begin
                        state_q <= FEED;
                        gnt_q   <= gnt_sel_d;
                        row_q   <= '0;
                    end
                end
                FEED: begin
                    // Rows keep flowing even if the requester drops out, so
                    // the transform never sees a partial block
                    tr_enable_q <= 1'b1;
                    tr_xxin_q   <= REQ_ROW[gnt_q];
                    if (!REQ_VALID[gnt_q]) begin
                        err_feed_q <= 1'b1;
                    end
                    row_q <= row_q + 1'b1;
                    if (row_q == 2'(ROWS_PER_BLK - 1)) begin
                        state_q <= HOLD;
                        hold_q  <= '0;
                    end
                end
                HOLD: begin
                    tr_enable_q <= 1'b0;
                    hold_q      <= hold_q + 1'b1;
                    if (hold_q == 2'(HOLD_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    tr_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_pop = TR_VALID && (beat_q == 4'd15);

    h264_ts_tagfifo #(
        .TFIFO_DEPTH (TFIFO_DEPTH)
    ) u_tagfifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (grant_d),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Label each returning coefficient with its owning block and zigzag index
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_src_q   <= 1'b0;
            out_tag_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            beat_q      <= '0;
            err_empty_q <= 1'b0;
        end else begin
            out_valid_q <= TR_VALID;
            out_last_q  <= TR_VALID && (beat_q == 4'd15);
            if (TR_VALID) begin
                out_coef_q <= TR_YNOUT;
                out_idx_q  <= beat_q;
                beat_q     <= beat_q + 1'b1;
                if (fifo_empty) begin
                    out_src_q   <= 1'b0;
                    out_tag_q   <= '0;
                    err_empty_q <= 1'b1;
                end else begin
                    out_src_q <= head_entry.src;
                    out_tag_q <= TAGW'(head_entry.tag);
                end
            end
        end
    end

    assign TR_ENABLE = tr_enable_q;
    assign TR_XXIN   = tr_xxin_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_COEF  = out_coef_q;
    assign OUT_SRC   = out_src_q;
    assign OUT_TAG   = out_tag_q;
    assign OUT_IDX   = out_idx_q;
    assign OUT_LAST  = out_last_q;
    assign ERR       = {err_empty_q, err_feed_q};

endmodule

// File: tb/tb_h264_transform_scheduler.sv
// Directed bench for h264_transform_scheduler with row and coefficient
// scoreboards. Honours H264_TS_LUMA_PRIO_EN for the arbitration order.
`timescale 1ns/1ps
module tb_h264_transform_scheduler;

    localparam int TAGW        = 6;
    localparam int TFIFO_DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [1:0]           REQ_VALID;
    logic [1:0][35:0]     REQ_ROW;
    logic [1:0][TAGW-1:0] REQ_TAG;
    logic [1:0]           REQ_ACK;
    logic                 TR_READY;
    logic                 TR_ENABLE;
    logic [35:0]          TR_XXIN;
    logic                 TR_VALID;
    logic [13:0]          TR_YNOUT;
    logic                 OUT_VALID;
    logic [13:0]          OUT_COEF;
    logic                 OUT_SRC;
    logic [TAGW-1:0]      OUT_TAG;
    logic [3:0]           OUT_IDX;
    logic                 OUT_LAST;
    logic [1:0]           ERR;

    always #5 CLK = ~CLK;

    h264_transform_scheduler #(
        .TAGW        (TAGW),
        .TFIFO_DEPTH (TFIFO_DEPTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_ROW   (REQ_ROW),
        .REQ_TAG   (REQ_TAG),
        .REQ_ACK   (REQ_ACK),
        .TR_READY  (TR_READY),
        .TR_ENABLE (TR_ENABLE),
        .TR_XXIN   (TR_XXIN),
        .TR_VALID  (TR_VALID),
        .TR_YNOUT  (TR_YNOUT),
        .OUT_VALID (OUT_VALID),
        .OUT_COEF  (OUT_COEF),
        .OUT_SRC   (OUT_SRC),
        .OUT_TAG   (OUT_TAG),
        .OUT_IDX   (OUT_IDX),
        .OUT_LAST  (OUT_LAST),
        .ERR       (ERR)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [35:0] row_exp_q [$];   // rows the transform must receive, in order
    logic [25:0] out_exp_q [$];   // {coef, src, tag, idx, last}
    logic [6:0]  own_q     [$];   // model of the tag FIFO: {src, tag}
    int          beat_m = 0;      // model of the beat counter

    int   en_start_q  [$];
    int   ack_start_q [$];
    int   en_len = 0;
    logic [1:0] ack_prev = 2'b00;
    int   ack_cnt [2] = '{0, 0};

    // ---------------- requester model ----------------
    int              tgt    [2] = '{0, 0};  // blocks requested (stimulus side)
    int              done_q [2] = '{0, 0};  // blocks fully acknowledged
    int              ridx_q [2] = '{0, 0};  // current row within block
    logic            drop_arm [2];
    logic [TAGW-1:0] tag_r [2];

    function automatic logic [35:0] row_val(input int r, input int b, input int i);
        logic [8:0] p0, p1, p2, p3;
        p0 = 9'(i + 1);
        p1 = 9'(b);
        p2 = 9'(r);
        p3 = 9'(i + 1) ^ 9'h100;
        return {p3, p2, p1, p0};
    endfunction

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            REQ_VALID[r] = (done_q[r] < tgt[r]) && !(drop_arm[r] && ridx_q[r] >= 2);
            REQ_ROW[r]   = row_val(r, done_q[r], ridx_q[r]);
            REQ_TAG[r]   = tag_r[r];
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int r = 0; r < 2; r++) begin
            if (!RESET) begin
                ridx_q[r] <= 0;
                done_q[r] <= tgt[r];
            end else if (REQ_ACK[r]) begin
                if (ridx_q[r] == 3) begin
                    ridx_q[r] <= 0;
                    done_q[r] <= done_q[r] + 1;
                end else begin
                    ridx_q[r] <= ridx_q[r] + 1;
                end
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge CLK) begin
        logic [35:0] er;
        logic [25:0] eo;
        if (!RESET) begin
            en_len   = 0;
            ack_prev = 2'b00;
        end else begin
            if (TR_ENABLE) begin
                if (en_len == 0) en_start_q.push_back(cyc);
                en_len++;
                chk("row_expected", 64'(row_exp_q.size() != 0), 64'd1);
                if (row_exp_q.size() != 0) begin
                    er = row_exp_q.pop_front();
                    chk("tr_xxin", 64'(TR_XXIN), 64'(er));
                end
            end else if (en_len != 0) begin
                chk("enable_len", 64'(en_len), 64'd4);
                en_len = 0;
            end
            if (REQ_ACK != 2'b00 && ack_prev == 2'b00) ack_start_q.push_back(cyc);
            for (int r = 0; r < 2; r++) ack_cnt[r] += int'(REQ_ACK[r]);
            ack_prev = REQ_ACK;
            if (OUT_VALID) begin
                chk("out_expected", 64'(out_exp_q.size() != 0), 64'd1);
                if (out_exp_q.size() != 0) begin
                    eo = out_exp_q.pop_front();
                    chk("out_beat", 64'({OUT_COEF, OUT_SRC, OUT_TAG, OUT_IDX, OUT_LAST}), 64'(eo));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_block(input int r, input int b);
        for (int i = 0; i < 4; i++) row_exp_q.push_back(row_val(r, b, i));
        own_q.push_back({1'(r), tag_r[r]});
    endtask

    task automatic wait_rows(input string tag, input int budget);
        int n;
        n = 0;
        while (row_exp_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(tag, 64'(row_exp_q.size()), 64'd0);
    endtask

    task automatic drive_beats(input int n);
        for (int k = 0; k < n; k++) begin
            logic [13:0] c;
            logic [6:0]  own;
            logic        last;
            c    = 14'($urandom_range(0, 16383));
            own  = (own_q.size() != 0) ? own_q[0] : 7'd0;
            last = (beat_m == 15);
            out_exp_q.push_back({c, own, 4'(beat_m), last});
            if (last && own_q.size() != 0) void'(own_q.pop_front());
            beat_m   = (beat_m + 1) % 16;
            TR_VALID = 1'b1;
            TR_YNOUT = c;
            @(posedge CLK);
            #1;
        end
        TR_VALID = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_req_ack"},   64'(REQ_ACK),   64'd0);
        chk({pfx, "_tr_enable"}, 64'(TR_ENABLE), 64'd0);
        chk({pfx, "_tr_xxin"},   64'(TR_XXIN),   64'd0);
        chk({pfx, "_out_valid"}, 64'(OUT_VALID), 64'd0);
        chk({pfx, "_out_coef"},  64'(OUT_COEF),  64'd0);
        chk({pfx, "_out_src"},   64'(OUT_SRC),   64'd0);
        chk({pfx, "_out_tag"},   64'(OUT_TAG),   64'd0);
        chk({pfx, "_out_idx"},   64'(OUT_IDX),   64'd0);
        chk({pfx, "_out_last"},  64'(OUT_LAST),  64'd0);
        chk({pfx, "_err"},       64'(ERR),       64'd0);
    endtask

    // Safety net in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0, a1, n;
        RESET       = 1'b0;
        TR_READY    = 1'b0;
        TR_VALID    = 1'b0;
        TR_YNOUT    = '0;
        drop_arm[0] = 1'b0;
        drop_arm[1] = 1'b0;
        tag_r[0]    = 6'h11;
        tag_r[1]    = 6'h2A;
        tick(3);

        // Reset values
        @(negedge CLK);
        check_idle_outputs("rst");
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Luma only; TR_READY low holds off the grant
        expect_block(0, tgt[0]);
        tgt[0]++;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("not_ready_no_ack", 64'(REQ_ACK), 64'd0);
            @(posedge CLK); #1;
        end
        en_start_q.delete();
        ack_start_q.delete();
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        TR_READY = 1'b1;
        wait_rows("t1_rows", 40);
        tick(3);
        chk("t1_ack_luma", 64'(ack_cnt[0] - a0), 64'd4);
        chk("t1_ack_chroma", 64'(ack_cnt[1] - a1), 64'd0);
        chk("t1_en_runs", 64'(en_start_q.size()), 64'd1);
        // first row strobe follows the first ACK cycle by one cycle
        chk("t1_ack_to_en", 64'(en_start_q[0] - ack_start_q[0]), 64'd1);
        drive_beats(16);
        tick(2);
        chk("t1_out_drained", 64'(out_exp_q.size()), 64'd0);

        // Chroma alone, tag 0x2A, 16 labelled beats
        expect_block(1, tgt[1]);
        tgt[1]++;
        wait_rows("t2_rows", 40);
        tick(3);
        drive_beats(16);
        tick(2);
        chk("t2_out_drained", 64'(out_exp_q.size()), 64'd0);

        // Both requesters valid together
        en_start_q.delete();
`ifdef H264_TS_LUMA_PRIO_EN
        expect_block(0, tgt[0]);
        expect_block(0, tgt[0] + 1);
        expect_block(1, tgt[1]);
`else
        expect_block(0, tgt[0]);
        expect_block(1, tgt[1]);
        expect_block(0, tgt[0] + 1);
`endif
        tgt[0] += 2;
        tgt[1] += 1;
        wait_rows("t3_rows", 100);
        tick(3);
        chk("t3_en_runs", 64'(en_start_q.size()), 64'd3);
        chk("t3_spacing_a", 64'(en_start_q[1] - en_start_q[0]), 64'd7);
        chk("t3_spacing_b", 64'(en_start_q[2] - en_start_q[1]), 64'd7);
        drive_beats(48);
        tick(2);
        chk("t3_out_drained", 64'(out_exp_q.size()), 64'd0);

        // Fill the tag FIFO, then a chroma request must wait for a pop
        for (int k = 0; k < TFIFO_DEPTH; k++) expect_block(0, tgt[0] + k);
        tgt[0] += TFIFO_DEPTH;
        wait_rows("t4_fill_rows", 120);
        tick(3);
        expect_block(1, tgt[1]);
        tgt[1]++;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("full_no_ack", 64'(REQ_ACK), 64'd0);
            @(posedge CLK); #1;
        end
        drive_beats(16);
        @(negedge CLK);
        chk("pop_edge_no_ack", 64'(REQ_ACK), 64'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("grant_after_pop", 64'(REQ_ACK), 64'd2);
        @(posedge CLK); #1;
        wait_rows("t4_rows", 40);
        tick(3);
        drive_beats(16 * TFIFO_DEPTH);
        tick(2);
        chk("t4_out_drained", 64'(out_exp_q.size()), 64'd0);

        // Chroma drops REQ_VALID from row 2; block still fed whole
        chk("err_clean", 64'(ERR), 64'd0);
        drop_arm[1] = 1'b1;
        a1 = ack_cnt[1];
        expect_block(1, tgt[1]);
        tgt[1]++;
        wait_rows("t5_rows", 40);
        tick(3);
        chk("drop_err0", 64'(ERR), 64'd1);
        chk("drop_acks", 64'(ack_cnt[1] - a1), 64'd4);
        drop_arm[1] = 1'b0;
        drive_beats(16);
        tick(2);
        chk("drained_err", 64'(ERR), 64'd1);
        // FIFO is empty now: one stray coefficient
        drive_beats(1);
        tick(2);
        chk("empty_err1", 64'(ERR), 64'd3);
        chk("t5_out_drained", 64'(out_exp_q.size()), 64'd0);

        // Reset in the middle of FEED
        expect_block(0, tgt[0]);
        tgt[0]++;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!REQ_ACK[0] && n < 20);
        chk("t6_feed_started", 64'(REQ_ACK[0]), 64'd1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check_idle_outputs("midrst");
        row_exp_q.delete();
        own_q.delete();
        out_exp_q.delete();
        beat_m = 0;
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Fresh blocks after reset: pointer favours luma again
        expect_block(0, tgt[0]);
        expect_block(1, tgt[1]);
        tgt[0]++;
        tgt[1]++;
        wait_rows("t6_rows", 60);
        tick(3);
        drive_beats(32);
        tick(2);
        chk("t6_out_drained", 64'(out_exp_q.size()), 64'd0);
        chk("t6_own_drained", 64'(own_q.size()), 64'd0);
        chk("t6_err", 64'(ERR), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
